program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: streams 128 bytes into a 32-word instruction image, holds the
// core in reset for HOLD_CYCLES cycles after the last byte, then releases it.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing mod-256
// checksum byte; a mismatch sets the sticky err flag and aborts to idle.
module program_loader #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [1023:0] i_memory_image,
    output logic          core_rstn,
    output logic          load_done,
    output logic [7:0]    byte_count,
    output logic          err
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StRun
    } state_e;

    state_e          state_q;
    logic [1023:0]   image_q;
    logic [7:0]      count_q;
    logic [7:0]      hold_cnt_q;
    logic            in_ready_q;
    logic            core_rstn_q;
    logic            load_done_q;
    logic            accept;

    // in_ready_q is only ever high in StLoad, so it doubles as the load qualifier.
    assign accept = in_valid & in_ready_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       err_q;

    // Load FSM with registered outputs, checksum variant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            image_q     <= '0;
            count_q     <= '0;
            hold_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
            load_done_q <= 1'b0;
            sum_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (start) begin
                        state_q     <= StLoad;
                        image_q     <= '0;
                        count_q     <= '0;
                        sum_q       <= '0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        core_rstn_q <= 1'b0;
                        load_done_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        count_q <= count_q + 8'd1;
                        if (count_q[7]) begin
                            // Byte 128 is the checksum; it never lands in the image.
                            in_ready_q <= 1'b0;
                            if (in_data == sum_q) begin
                                state_q    <= StHold;
                                hold_cnt_q <= 8'(HOLD_CYCLES - 1);
                            end else begin
                                state_q <= StIdle;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            image_q[{count_q[6:0], 3'b000} +: 8] <= in_data;
                            sum_q <= sum_q + in_data;
                        end
                    end
                end
                StHold: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q     <= StRun;
                        core_rstn_q <= 1'b1;
                        load_done_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign err = err_q;
`else
    // Load FSM with registered outputs, plain 128-byte variant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            image_q     <= '0;
            count_q     <= '0;
            hold_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    if (start) begin
                        state_q     <= StLoad;
                        image_q     <= '0;
                        count_q     <= '0;
                        in_ready_q  <= 1'b1;
                        core_rstn_q <= 1'b0;
                        load_done_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        count_q <= count_q + 8'd1;
                        image_q[{count_q[6:0], 3'b000} +: 8] <= in_data;
                        if (count_q == 8'd127) begin
                            state_q    <= StHold;
                            in_ready_q <= 1'b0;
                            hold_cnt_q <= 8'(HOLD_CYCLES - 1);
                        end
                    end
                end
                StHold: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q     <= StRun;
                        core_rstn_q <= 1'b1;
                        load_done_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign err = 1'b0;
`endif

    assign in_ready       = in_ready_q;
    assign i_memory_image = image_q;
    assign core_rstn      = core_rstn_q;
    assign load_done      = load_done_q;
    assign byte_count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    localparam int unsigned HoldCycles = 4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [7:0] FinalCount = 8'd129;
`else
    localparam logic [7:0] FinalCount = 8'd128;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [1023:0] i_memory_image;
    logic          core_rstn;
    logic          load_done;
    logic [7:0]    byte_count;
    logic          err;

    logic [1023:0] exp_image;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    program_loader #(.HOLD_CYCLES(HoldCycles)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .i_memory_image (i_memory_image),
        .core_rstn      (core_rstn),
        .load_done      (load_done),
        .byte_count     (byte_count),
        .err            (err)
    );

    function automatic int first_diff_word(input logic [1023:0] a, input logic [1023:0] b);
        for (int w = 0; w < 32; w++) begin
            if (a[32*w +: 32] !== b[32*w +: 32]) return w;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
        in_valid = 1'b1; in_data = b; start = with_start;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'hA5; start = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Sends bytes 0..127 (plus the correct checksum when enabled); start_at < 0 means no start.
    task automatic send_image(input bit gap, input int start_at);
        for (int i = 0; i < 128; i++) send_byte(8'(i), gap, i == start_at);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hC0, gap, 1'b0);
`endif
    endtask

    task automatic check_image(input string name, input logic [1023:0] exp);
        int w;
        total++;
        if (i_memory_image !== exp) begin
            bad++;
            w = first_diff_word(i_memory_image, exp);
            $display("FAIL %s: word%0d got %h want %h", name, w,
                     i_memory_image[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, core_rstn, load_done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {in_ready, core_rstn, load_done, err});
        end
        total++;
        if (byte_count !== 8'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", byte_count);
        end
        check_image("reset_image", '0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        apply_reset();
        pulse_start();
        total++;
        if (in_ready !== 1'b1 || byte_count !== 8'd0) begin
            bad++; $display("FAIL load_entry: in_ready=%b count=%0d want 1/0", in_ready, byte_count);
        end
        send_image(1'b0, -1);
        total++;
        if (in_ready !== 1'b0 || byte_count !== FinalCount) begin
            bad++;
            $display("FAIL load_end: in_ready=%b count=%0d want 0/%0d", in_ready, byte_count, FinalCount);
        end
        total++;
        if (i_memory_image[31:0] !== 32'h03020100) begin
            bad++; $display("FAIL word0: got %h want 03020100", i_memory_image[31:0]);
        end
        check_image("full_image", exp_image);
        for (int c = 1; c <= int'(HoldCycles); c++) begin
            @(negedge clk);
            total++;
            if (core_rstn !== (c == int'(HoldCycles)) || load_done !== (c == int'(HoldCycles))) begin
                bad++;
                $display("FAIL hold_cycle%0d: core_rstn=%b load_done=%b want %0d", c, core_rstn,
                         load_done, c == int'(HoldCycles));
            end
        end
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_clean: got %b want 0", err);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(8'(i), 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (byte_count !== 8'd11 || in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_hold: count=%0d in_ready=%b want 11/1", byte_count, in_ready);
        end
        for (int i = 11; i < 128; i++) send_byte(8'(i), 1'b1, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hC0, 1'b1, 1'b0);
`endif
        total++;
        if (byte_count !== FinalCount) begin
            bad++; $display("FAIL stall_count: got %0d want %0d", byte_count, FinalCount);
        end
        check_image("stall_image", exp_image);
        repeat (HoldCycles) @(negedge clk);
        total++;
        if (core_rstn !== 1'b1 || load_done !== 1'b1) begin
            bad++; $display("FAIL stall_run: core_rstn=%b load_done=%b want 1/1", core_rstn, load_done);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        pulse_start();
        for (int i = 0; i < 50; i++) send_byte(8'(i), 1'b0, 1'b0);
        total++;
        if (byte_count !== 8'd50) begin
            bad++; $display("FAIL abort_pre: count=%0d want 50", byte_count);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, core_rstn, load_done, err} !== 4'b0000 || byte_count !== 8'd0) begin
            bad++;
            $display("FAIL abort_async: flags=%b count=%0d want 0000/0",
                     {in_ready, core_rstn, load_done, err}, byte_count);
        end
        check_image("abort_image", '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b0 || byte_count !== 8'd0) begin
            bad++; $display("FAIL no_start: in_ready=%b count=%0d want 0/0", in_ready, byte_count);
        end
        check_image("no_start_image", '0);
    endtask

    task automatic test_start_ignored();
        apply_reset();
        pulse_start();
        send_image(1'b0, 20);
        total++;
        if (byte_count !== FinalCount) begin
            bad++; $display("FAIL start_in_load: count=%0d want %0d", byte_count, FinalCount);
        end
        check_image("start_in_load_image", exp_image);
        // Start during the first hold cycle must not disturb the hold countdown.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (HoldCycles - 1) @(negedge clk);
        total++;
        if (core_rstn !== 1'b1 || load_done !== 1'b1) begin
            bad++; $display("FAIL start_in_hold: core_rstn=%b load_done=%b want 1/1", core_rstn, load_done);
        end
        for (int i = 0; i < 3; i++) send_byte(8'hEE, 1'b0, 1'b0);
        total++;
        if (byte_count !== FinalCount || in_ready !== 1'b0) begin
            bad++; $display("FAIL run_valid: count=%0d in_ready=%b want %0d/0", byte_count, in_ready, FinalCount);
        end
        check_image("run_image_stable", exp_image);
        pulse_start();
        total++;
        if ({core_rstn, load_done, in_ready} !== 3'b001 || byte_count !== 8'd0) begin
            bad++;
            $display("FAIL restart: rstn/done/ready=%b count=%0d want 001/0",
                     {core_rstn, load_done, in_ready}, byte_count);
        end
        check_image("restart_image", '0);
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        apply_reset();
        pulse_start();
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_byte(8'hC1, 1'b0, 1'b0);
        total++;
        if ({err, in_ready, core_rstn, load_done} !== 4'b1000 || byte_count !== 8'd129) begin
            bad++;
            $display("FAIL csum_bad: err/ready/rstn/done=%b count=%0d want 1000/129",
                     {err, in_ready, core_rstn, load_done}, byte_count);
        end
        repeat (HoldCycles + 2) @(negedge clk);
        send_byte(8'h11, 1'b0, 1'b0);
        total++;
        if ({err, core_rstn, load_done} !== 3'b100 || byte_count !== 8'd129) begin
            bad++;
            $display("FAIL csum_idle: err/rstn/done=%b count=%0d want 100/129",
                     {err, core_rstn, load_done}, byte_count);
        end
        pulse_start();
        total++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL csum_clear: err=%b in_ready=%b want 0/1", err, in_ready);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) exp_image[8*i +: 8] = 8'(i);
        test_reset();
        test_full_load();
        test_stall();
        test_abort();
        test_start_ignored();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
